dbus_mem_responder: RTL and testbench

- Data-side memory responder for the CortexM0 data bus; the target end of the DREQ/DADDR/DRW/DSIZE/DIN/DOUT protocol.
- Replaces the generic dual-port SRAM plus external byte-enable logic on the data side with one self-contained block.
- Decodes size and alignment, performs byte-lane writes, and returns read data with fixed 1-cycle latency.
- Flags illegal accesses and captures the first faulting address.

---
 rtl/dbus_pkg.sv | 31 +++
 rtl/dbus_be_decode.sv | 16 +
 rtl/dbus_mem_responder.sv | 106 ++++++++++
 tb/tb_dbus_mem_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared data-bus definitions: DSIZE encodings, byte-enable lookup, counter width.
package dbus_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE    = 2'b00,
      SZ_HALF    = 2'b01,
      SZ_WORD    = 2'b10,
      SZ_ILLEGAL = 2'b11
   } dsize_e;

   localparam int CNT_W = 16;

   // Returns {legal, be[3:0]} for a DSIZE / DADDR[1:0] pair.
   function automatic logic [4:0] be_lookup(input logic [1:0] size, input logic [1:0] lsb);
      logic [4:0] r;
      // NOTE: default assigned before the case so every path drives r; no latch when used combinationally.
      r = 5'b0_0000;
      case ({size, lsb})
         {SZ_BYTE, 2'b00}: r = 5'b1_0001;
         {SZ_BYTE, 2'b01}: r = 5'b1_0010;
         {SZ_BYTE, 2'b10}: r = 5'b1_0100;
         {SZ_BYTE, 2'b11}: r = 5'b1_1000;
         {SZ_HALF, 2'b00}: r = 5'b1_0011;
         {SZ_HALF, 2'b10}: r = 5'b1_1100;
         {SZ_WORD, 2'b00}: r = 5'b1_1111;
         default:          r = 5'b0_0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dbus_be_decode.sv
// Combinational DSIZE / address-LSB decode to byte enables and a misalignment flag.
module dbus_be_decode
   import dbus_pkg::*;
(
   input  logic [1:0] size,
   input  logic [1:0] addr_lsb,
   output logic [3:0] be,
   output logic       misaligned
);

   logic legal;

   assign {legal, be} = be_lookup(size, addr_lsb);
   assign misaligned  = ~legal;

endmodule

// File: rtl/dbus_mem_responder.sv
// Data-bus memory responder: byte-lane writes, 1-cycle reads, fault capture.
// Optional access counters are built when DMEM_ACCESS_CNT_EN is defined.
module dbus_mem_responder
   import dbus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 4096,
   parameter int          AW          = 12
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             DREQ,
   input  logic [31:0]      DADDR,
   input  logic             DRW,
   input  logic [1:0]       DSIZE,
   input  logic [31:0]      DOUT,
   output logic [31:0]      DIN,
   output logic             ERR,
   output logic             FAULT,
   output logic [31:0]      FAULT_ADDR,
   input  logic             FAULT_CLR,
   output logic [CNT_W-1:0] RD_CNT,
   output logic [CNT_W-1:0] WR_CNT
);

   // 33 bits so the span cannot wrap for large bases or depths.
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

   logic [31:0]   offset;
   logic          in_range;
   logic          misaligned;
   logic [3:0]    be;
   logic [AW-1:0] idx;
   logic          acc_ok;
   logic          do_wr;
   logic          do_rd;
   logic          fault_now;

   logic [31:0] mem [DEPTH_WORDS];

   dbus_be_decode u_be_decode (
      .size       (DSIZE),
      .addr_lsb   (DADDR[1:0]),
      .be         (be),
      .misaligned (misaligned)
   );

   assign offset    = DADDR - BASE_ADDR;
   assign in_range  = (DADDR >= BASE_ADDR) && ({1'b0, offset} < SPAN);
   assign idx       = offset[AW+1:2];
   assign acc_ok    = in_range & ~misaligned;
   assign do_wr     = DREQ & acc_ok & DRW;
   assign do_rd     = DREQ & acc_ok & ~DRW;
   assign fault_now = DREQ & ~acc_ok;

   // NOTE: the array has no reset branch; clearing it would force it out of RAM into flops.
   always_ff @(posedge CLK) begin
      if (do_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= DOUT[8*i +: 8];
         end
      end
   end

   // NOTE: state is assigned with <= so every flop samples pre-edge values, matching hardware.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         DIN        <= '0;
         ERR        <= 1'b0;
         FAULT      <= 1'b0;
         FAULT_ADDR <= '0;
      end else begin
         ERR <= fault_now;
         if (fault_now)  DIN <= '0;
         else if (do_rd) DIN <= mem[idx];

         // A new fault beats a same-cycle clear and re-captures its address.
         if (fault_now) begin
            FAULT <= 1'b1;
            if (!FAULT || FAULT_CLR) FAULT_ADDR <= DADDR;
         end else if (FAULT_CLR) begin
            FAULT      <= 1'b0;
            FAULT_ADDR <= '0;
         end
      end
   end

`ifdef DMEM_ACCESS_CNT_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         RD_CNT <= '0;
         WR_CNT <= '0;
      end else if (FAULT_CLR) begin
         RD_CNT <= '0;
         WR_CNT <= '0;
      end else begin
         if (do_rd && (RD_CNT != '1)) RD_CNT <= RD_CNT + 1'b1;
         if (do_wr && (WR_CNT != '1)) WR_CNT <= WR_CNT + 1'b1;
      end
   end
`else
   assign RD_CNT = '0;
   assign WR_CNT = '0;
`endif

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Self-checking bench for dbus_mem_responder: directed scenarios plus random traffic against a reference model.
module tb_dbus_mem_responder;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          DEPTH = 4096;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        DREQ;
   logic [31:0] DADDR;
   logic        DRW;
   logic [1:0]  DSIZE;
   logic [31:0] DOUT;
   logic [31:0] DIN;
   logic        ERR;
   logic        FAULT;
   logic [31:0] FAULT_ADDR;
   logic        FAULT_CLR;
   logic [15:0] RD_CNT;
   logic [15:0] WR_CNT;

   dbus_mem_responder #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (DEPTH),
      .AW          (12)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .DREQ       (DREQ),
      .DADDR      (DADDR),
      .DRW        (DRW),
      .DSIZE      (DSIZE),
      .DOUT       (DOUT),
      .DIN        (DIN),
      .ERR        (ERR),
      .FAULT      (FAULT),
      .FAULT_ADDR (FAULT_ADDR),
      .FAULT_CLR  (FAULT_CLR),
      .RD_CNT     (RD_CNT),
      .WR_CNT     (WR_CNT)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model state: word-indexed memory and expected outputs.
   logic [31:0] ref_mem [int];
   logic [31:0] exp_din;
   logic        exp_err;
   logic        exp_fault;
   logic [31:0] exp_faddr;
   int          exp_rd;
   int          exp_wr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit legal_access(input logic [31:0] addr, input logic [1:0] size);
      longint off;
      int     nbytes;
      off = longint'(addr) - longint'(BASE);
      if (size == 2'b11) return 1'b0;
      nbytes = 1 << size;
      if ((addr % nbytes) != 0) return 1'b0;
      return (off >= 0) && (off < 4 * DEPTH);
   endfunction

   task automatic model_step(input bit req, input logic [31:0] addr, input bit rw,
                             input logic [1:0] size, input logic [31:0] data, input bit clr);
      bit          faulted;
      int          w;
      int          lane;
      int          n;
      logic [31:0] word;
      faulted = 1'b0;
      exp_err = 1'b0;
      if (req) begin
         if (!legal_access(addr, size)) begin
            exp_err = 1'b1;
            exp_din = 32'h0;
            if (!exp_fault || clr) exp_faddr = addr;
            exp_fault = 1'b1;
            faulted   = 1'b1;
         end else begin
            w    = int'((addr - BASE) / 4);
            lane = int'(addr % 4);
            n    = 1 << size;
            if (rw) begin
               word = ref_mem[w];
               for (int b = lane; b < lane + n; b++) word[8*b +: 8] = data[8*b +: 8];
               ref_mem[w] = word;
               if (exp_wr < 65535) exp_wr++;
            end else begin
               exp_din = ref_mem[w];
               if (exp_rd < 65535) exp_rd++;
            end
         end
      end
      if (clr) begin
         if (!faulted) begin
            exp_fault = 1'b0;
            exp_faddr = 32'h0;
         end
         exp_rd = 0;
         exp_wr = 0;
      end
   endtask

   task automatic check_outputs(input string tag);
      int rd_e;
      int wr_e;
`ifdef DMEM_ACCESS_CNT_EN
      rd_e = exp_rd;
      wr_e = exp_wr;
`else
      rd_e = 0;
      wr_e = 0;
`endif
      check({tag, ".err"},   32'(ERR),    32'(exp_err));
      check({tag, ".din"},   DIN,         exp_din);
      check({tag, ".fault"}, 32'(FAULT),  32'(exp_fault));
      check({tag, ".faddr"}, FAULT_ADDR,  exp_faddr);
      check({tag, ".rdcnt"}, 32'(RD_CNT), 32'(rd_e));
      check({tag, ".wrcnt"}, 32'(WR_CNT), 32'(wr_e));
   endtask

   task automatic access(input string tag, input bit req, input logic [31:0] addr, input bit rw,
                         input logic [1:0] size, input logic [31:0] data, input bit clr);
      @(negedge CLK);
      DREQ      = req;
      DADDR     = addr;
      DRW       = rw;
      DSIZE     = size;
      DOUT      = data;
      FAULT_CLR = clr;
      @(posedge CLK);
      model_step(req, addr, rw, size, data, clr);
      #1;
      check_outputs(tag);
   endtask

   task automatic model_reset();
      exp_din   = 32'h0;
      exp_err   = 1'b0;
      exp_fault = 1'b0;
      exp_faddr = 32'h0;
      exp_rd    = 0;
      exp_wr    = 0;
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      bit          rq;
      bit          rw;
      bit          cl;

      RESET     = 1'b1;
      DREQ      = 1'b0;
      DADDR     = 32'h0;
      DRW       = 1'b0;
      DSIZE     = 2'b00;
      DOUT      = 32'h0;
      FAULT_CLR = 1'b0;
      model_reset();
      repeat (2) @(negedge CLK);
      check_outputs("reset");
      RESET = 1'b0;

      // Preload words 0..31 so every later read has a known expectation.
      for (int i = 0; i < 32; i++) begin
         logic [31:0] d;
         d = $urandom;
         if (i == 8)  d = 32'h0000_0000;
         if (i == 12) d = 32'hFFFF_FFFF;
         access("preload", 1'b1, 32'(i * 4), 1'b1, SZ_WORD_C(), d, 1'b0);
      end

      access("wr10",  1'b1, 32'h10, 1'b1, 2'b10, 32'hDEAD_BEEF, 1'b0);
      access("rd10",  1'b1, 32'h10, 1'b0, 2'b10, 32'h0, 1'b0);
      check("rd10.const", DIN, 32'hDEAD_BEEF);

      access("wrb20", 1'b1, 32'h20, 1'b1, 2'b00, 32'h0000_00AA, 1'b0);
      access("wrb21", 1'b1, 32'h21, 1'b1, 2'b00, 32'h0000_BB00, 1'b0);
      access("rd20",  1'b1, 32'h20, 1'b0, 2'b10, 32'h0, 1'b0);
      check("rd20.const", DIN, 32'h0000_BBAA);

      access("wrh32", 1'b1, 32'h32, 1'b1, 2'b01, 32'h1234_0000, 1'b0);
      access("rd30",  1'b1, 32'h30, 1'b0, 2'b10, 32'h0, 1'b0);
      check("rd30.const", DIN, 32'h1234_FFFF);

      access("wrh41", 1'b1, 32'h41, 1'b1, 2'b01, 32'h5555_5555, 1'b0);
      check("wrh41.faddr.const", FAULT_ADDR, 32'h41);
      access("idle1", 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0);
      access("rd40",  1'b1, 32'h40, 1'b0, 2'b10, 32'h0, 1'b0);
      access("rdb4003", 1'b1, 32'h4003, 1'b0, 2'b00, 32'h0, 1'b0);
      check("second_fault.faddr.const", FAULT_ADDR, 32'h41);
      access("clr1",  1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b1);

      access("rd4000", 1'b1, 32'h4000, 1'b0, 2'b10, 32'h0, 1'b0);
      access("sz11",   1'b1, 32'h0,    1'b0, 2'b11, 32'h0, 1'b0);
      // Fault in the same cycle as a clear: the new address is captured.
      access("fault_clr", 1'b1, 32'h7, 1'b0, 2'b10, 32'h0, 1'b1);
      check("fault_clr.faddr.const", FAULT_ADDR, 32'h7);

      access("clr2",  1'b0, 32'h0,  1'b0, 2'b00, 32'h0, 1'b1);
      access("cnt_r1", 1'b1, 32'h10, 1'b0, 2'b10, 32'h0, 1'b0);
      access("cnt_r2", 1'b1, 32'h20, 1'b0, 2'b10, 32'h0, 1'b0);
      access("cnt_w1", 1'b1, 32'h50, 1'b1, 2'b10, 32'hA5A5_0001, 1'b0);
      access("cnt_r3", 1'b1, 32'h30, 1'b0, 2'b10, 32'h0, 1'b0);
      access("cnt_w2", 1'b1, 32'h54, 1'b1, 2'b10, 32'hA5A5_0002, 1'b0);
      access("cnt_f",  1'b1, 32'h3,  1'b1, 2'b10, 32'h0, 1'b0);
`ifdef DMEM_ACCESS_CNT_EN
      check("cnt.rd.const", 32'(RD_CNT), 32'd3);
      check("cnt.wr.const", 32'(WR_CNT), 32'd2);
`endif
      access("pre_rst", 1'b1, 32'h10, 1'b0, 2'b10, 32'h0, 1'b0);

      // Asynchronous reset in mid-cycle with the bus idle.
      @(negedge CLK);
      DREQ      = 1'b0;
      FAULT_CLR = 1'b0;
      #2 RESET = 1'b1;
      #1;
      model_reset();
      check_outputs("mid_reset");
      @(negedge CLK);
      RESET = 1'b0;

      for (int it = 0; it < 400; it++) begin
         rq = ($urandom_range(0, 99) < 85);
         rw = $urandom_range(0, 1) == 1;
         cl = ($urandom_range(0, 19) == 0);
         sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         if ($urandom_range(0, 9) == 0) a = 32'h4000 + 32'($urandom_range(0, 255));
         else                           a = 32'($urandom_range(0, 127));
         if ((sz != 2'b11) && ($urandom_range(0, 3) != 0)) a = a & ~((32'd1 << sz) - 32'd1);
         access("rand", rq, a, rw, sz, $urandom, cl);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   function automatic logic [1:0] SZ_WORD_C();
      return 2'b10;
   endfunction

endmodule
